// File: rtl/d_cache_dm_param.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Memory-side requests are held until addr_ok; uncached window 0xA000_0000-0xBFFF_FFFF bypasses the arrays.
module d_cache_dm_param #(
  parameter int INDEX_WIDTH = 7,
  parameter bit UNCACHED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  // state  | meaning
  // IDLE   | waiting for a CPU request; addr_ok follows cpu_data_req
  // LOOKUP | tag compare on the latched request; hit completes here
  // WB     | writing the dirty victim line back to memory
  // RM     | refilling the line from memory
  // UC     | forwarding an uncached access unmodified

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RM, UC} state_t;

  state_t                  r_state;
  logic                    r_wr;
  logic [1:0]              r_size;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_issued;
  logic [LINES-1:0]        r_valid;
  logic [LINES-1:0]        r_dirty;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [31:0]             r_data [LINES];

  logic [INDEX_WIDTH-1:0]  w_index;
  logic [TAG_W-1:0]        w_tag;
  logic [TAG_W-1:0]        w_line_tag;
  logic [31:0]             w_line_data;
  logic                    w_hit;
  logic                    w_uncached;
  logic                    w_req_en;
  logic                    w_mem_fire;
  logic                    w_mem_done;
  logic [3:0]              w_bmask;
  logic [31:0]             w_merged;

  assign w_index     = r_addr[INDEX_WIDTH+1:2];
  assign w_tag       = r_addr[31:INDEX_WIDTH+2];
  assign w_line_tag  = r_tag[w_index];
  assign w_line_data = r_data[w_index];
  assign w_hit       = r_valid[w_index] && (w_line_tag == w_tag);
  assign w_uncached  = (UNCACHED_EN == 1'b1) && (cpu_data_addr[31:29] == 3'b101);
  assign w_req_en    = rst && !r_issued &&
                       ((r_state == WB) || (r_state == RM) || (r_state == UC));
  assign w_mem_fire  = w_req_en && cache_data_addr_ok;
  // data_ok before the request was accepted is noise; a combined addr_ok+data_ok counts
  assign w_mem_done  = cache_data_data_ok && (r_issued || w_mem_fire);

  always_comb begin
    w_bmask = 4'b0000;
    case (r_size)
      2'd0:    w_bmask[r_addr[1:0]] = 1'b1;
      2'd1:    w_bmask = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_bmask = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      w_merged[8*b +: 8] = w_bmask[b] ? r_wdata[8*b +: 8] : w_line_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_issued <= 1'b0;
      r_valid  <= '0;
      r_dirty  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_data_addr_ok) begin
            r_wr    <= cpu_data_wr;
            r_size  <= cpu_data_size;
            r_addr  <= cpu_data_addr;
            r_wdata <= cpu_data_wdata;
            r_state <= w_uncached ? UC : LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            if (r_wr) r_dirty[w_index] <= 1'b1;
            r_state <= IDLE;
          end else if (r_valid[w_index] && r_dirty[w_index]) begin
            r_state <= WB;
          end else begin
            r_state <= RM;
          end
        end
        WB, RM, UC: begin
          if (w_mem_fire) r_issued <= 1'b1;
          if (w_mem_done) begin
            r_issued <= 1'b0;
            if (r_state == WB) begin
              r_dirty[w_index] <= 1'b0;
              r_state          <= RM;
            end else if (r_state == RM) begin
              r_valid[w_index] <= 1'b1;
              r_dirty[w_index] <= 1'b0;
              r_state          <= LOOKUP;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits mask their contents.
  always_ff @(posedge clk) begin
    if ((r_state == RM) && w_mem_done) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= cache_data_rdata;
    end else if ((r_state == LOOKUP) && w_hit && r_wr) begin
      r_data[w_index] <= w_merged;
    end
  end

  always_comb begin
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = 32'd0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'd0;
    cache_data_addr  = 32'd0;
    cache_data_wdata = 32'd0;
    if (rst) begin
      cache_data_size = 2'd2;
      case (r_state)
        IDLE: cpu_data_addr_ok = cpu_data_req;
        LOOKUP: begin
          if (w_hit) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = w_line_data;
          end
        end
        WB: begin
          cache_data_req   = w_req_en;
          cache_data_wr    = 1'b1;
          cache_data_addr  = {w_line_tag, w_index, 2'b00};
          cache_data_wdata = w_line_data;
        end
        RM: begin
          cache_data_req  = w_req_en;
          cache_data_addr = {w_tag, w_index, 2'b00};
        end
        UC: begin
          cache_data_req   = w_req_en;
          cache_data_wr    = r_wr;
          cache_data_size  = r_size;
          cache_data_addr  = r_addr;
          cache_data_wdata = r_wdata;
          if (w_mem_done) begin
            cpu_data_data_ok = 1'b1;
            cpu_data_rdata   = cache_data_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_d_cache_dm_param.sv
// Scoreboard bench for d_cache_dm_param: a behavioural memory checks every
// memory-side transaction against an expected queue; CPU responses are popped on data_ok.
module tb_d_cache_dm_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_data_req = 1'b0;
  logic        cpu_data_wr = 1'b0;
  logic [1:0]  cpu_data_size = 2'd0;
  logic [31:0] cpu_data_addr = 32'd0;
  logic [31:0] cpu_data_wdata = 32'd0;
  logic [31:0] cpu_data_rdata;
  logic        cpu_data_addr_ok;
  logic        cpu_data_data_ok;
  logic        cache_data_req;
  logic        cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr;
  logic [31:0] cache_data_wdata;
  logic [31:0] cache_data_rdata = 32'd0;
  logic        cache_data_addr_ok = 1'b0;
  logic        cache_data_data_ok = 1'b0;

  d_cache_dm_param #(.INDEX_WIDTH(7), .UNCACHED_EN(1'b1)) dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_txn_t;

  typedef struct packed {
    logic [31:0] rd;
    logic        chk;
  } cpu_exp_t;

  int          checks = 0;
  int          failures = 0;
  mem_txn_t    exp_mem_q[$];
  cpu_exp_t    exp_cpu_q[$];
  logic [31:0] mem [bit [31:0]];
  int          addr_delay = 0;
  bit          combined = 1'b0;
  int          mem_cnt = 0;

  int          m_wait = 0;
  bit          m_pending = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] m_hold = 32'd0;
  mem_txn_t    m_exp;

  // Behavioural memory: addr_ok after addr_delay waiting cycles, data_ok one cycle later (or same cycle).
  initial begin
    forever begin
      @(negedge clk);
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (!rst) begin
        m_wait    = 0;
        m_pending = 1'b0;
      end else if (m_pending) begin
        cache_data_data_ok = 1'b1;
        cache_data_rdata   = m_rdata;
        m_pending          = 1'b0;
      end else if (cache_data_req) begin
        if (m_wait == 0) begin
          m_hold = cache_data_addr;
        end else begin
          checks++;
          if (cache_data_addr !== m_hold) begin
            failures++;
            $display("FAIL mem_addr_stable got %h want %h", cache_data_addr, m_hold);
          end
        end
        if (m_wait < addr_delay) begin
          m_wait++;
        end else begin
          m_wait = 0;
          cache_data_addr_ok = 1'b1;
          mem_cnt++;
          m_rdata = mem.exists(cache_data_addr) ? mem[cache_data_addr] : 32'd0;
          if (cache_data_wr) mem[cache_data_addr] = cache_data_wdata;
          checks++;
          if (exp_mem_q.size() == 0) begin
            failures++;
            $display("FAIL mem_unexpected got wr=%0d size=%0d addr=%h wdata=%h want none",
                     cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata);
          end else begin
            m_exp = exp_mem_q.pop_front();
            if ({cache_data_wr, cache_data_size, cache_data_addr} !== {m_exp.wr, m_exp.size, m_exp.addr} ||
                (m_exp.wr && (cache_data_wdata !== m_exp.wdata))) begin
              failures++;
              $display("FAIL mem_txn got wr=%0d size=%0d addr=%h wdata=%h want wr=%0d size=%0d addr=%h wdata=%h",
                       cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata,
                       m_exp.wr, m_exp.size, m_exp.addr, m_exp.wdata);
            end
          end
          if (combined) begin
            cache_data_data_ok = 1'b1;
            cache_data_rdata   = m_rdata;
          end else begin
            m_pending = 1'b1;
          end
        end
      end else begin
        m_wait = 0;
      end
    end
  end

  function automatic void push_mem(input logic wr, input logic [1:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    mem_txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    exp_mem_q.push_back(t);
  endfunction

  task automatic cpu_op(input string name, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit chk_rd,
                        input int exp_lat, input int exp_mem);
    int       lat;
    int       start_cnt;
    cpu_exp_t e;
    e.rd = exp_rd; e.chk = chk_rd;
    exp_cpu_q.push_back(e);
    @(negedge clk);
    start_cnt      = mem_cnt;
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    #1;
    checks++;
    if (cpu_data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL %s_addr_ok got %b want 1", name, cpu_data_addr_ok);
    end
    @(posedge clk);
    #1;
    cpu_data_req = 1'b0;
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      #2;
      if (cpu_data_data_ok) begin
        lat = c;
        e = exp_cpu_q.pop_front();
        if (e.chk) begin
          checks++;
          if (cpu_data_rdata !== e.rd) begin
            failures++;
            $display("FAIL %s_rdata got %h want %h", name, cpu_data_rdata, e.rd);
          end
        end
      end
    end
    checks++;
    if (lat == 0) begin
      failures++;
      $display("FAIL %s_timeout got no data_ok want data_ok within 60 cycles", name);
      void'(exp_cpu_q.pop_front());
    end else if (exp_lat > 0 && lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    @(negedge clk);
    #2;
    checks++;
    if (cpu_data_data_ok !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse got data_ok=%b want 0", name, cpu_data_data_ok);
    end
    checks++;
    if (mem_cnt - start_cnt != exp_mem) begin
      failures++;
      $display("FAIL %s_mem_count got %0d want %0d", name, mem_cnt - start_cnt, exp_mem);
    end
  endtask

  task automatic test_reset();
    cpu_data_req  = 1'b1;
    cpu_data_addr = 32'h0000_0010;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({cpu_data_addr_ok, cpu_data_data_ok, cache_data_req, cache_data_wr} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got %b want 0000",
               {cpu_data_addr_ok, cpu_data_data_ok, cache_data_req, cache_data_wr});
    end
    checks++;
    if ({cache_data_size, cache_data_addr, cache_data_wdata, cpu_data_rdata} !== 98'd0) begin
      failures++;
      $display("FAIL reset_data got size=%0d addr=%h wdata=%h rdata=%h want all 0",
               cache_data_size, cache_data_addr, cache_data_wdata, cpu_data_rdata);
    end
    cpu_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_read();
    push_mem(1'b0, 2'd2, 32'h0000_0010, 32'd0);
    cpu_op("cold_read", 1'b0, 2'd2, 32'h0000_0010, 32'd0, 32'h1122_3344, 1'b1, 4, 1);
    cpu_op("hit_read", 1'b0, 2'd2, 32'h0000_0010, 32'd0, 32'h1122_3344, 1'b1, 1, 0);
  endtask

  task automatic test_byte_write();
    cpu_op("byte_write", 1'b1, 2'd0, 32'h0000_0011, 32'h0000_AB00, 32'd0, 1'b0, 1, 0);
    cpu_op("merged_read", 1'b0, 2'd2, 32'h0000_0010, 32'd0, 32'h1122_AB44, 1'b1, 1, 0);
  endtask

  task automatic test_conflict();
    push_mem(1'b1, 2'd2, 32'h0000_0010, 32'h1122_AB44);
    push_mem(1'b0, 2'd2, 32'h0000_0210, 32'd0);
    cpu_op("conflict_read", 1'b0, 2'd2, 32'h0000_0210, 32'd0, 32'h5566_7788, 1'b1, 6, 2);
  endtask

  task automatic test_uncached();
    push_mem(1'b1, 2'd1, 32'hA000_0002, 32'hBEEF_0000);
    cpu_op("uc_write", 1'b1, 2'd1, 32'hA000_0002, 32'hBEEF_0000, 32'd0, 1'b0, 2, 1);
    push_mem(1'b0, 2'd1, 32'hA000_0002, 32'd0);
    cpu_op("uc_read", 1'b0, 2'd1, 32'hA000_0002, 32'd0, 32'hBEEF_0000, 1'b1, 2, 1);
    cpu_op("post_uc_hit", 1'b0, 2'd2, 32'h0000_0210, 32'd0, 32'h5566_7788, 1'b1, 1, 0);
  endtask

  task automatic test_reset_wb();
    bit seen;
    cpu_op("dirty_write", 1'b1, 2'd2, 32'h0000_0210, 32'hCAFE_F00D, 32'd0, 1'b0, 1, 0);
    addr_delay = 20;
    @(negedge clk);
    cpu_data_req  = 1'b1;
    cpu_data_wr   = 1'b0;
    cpu_data_size = 2'd2;
    cpu_data_addr = 32'h0000_0010;
    @(posedge clk);
    #1;
    cpu_data_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #2;
      seen = cache_data_req;
    end
    checks++;
    if (!seen || {cache_data_wr, cache_data_addr, cache_data_wdata} !== {1'b1, 32'h0000_0210, 32'hCAFE_F00D}) begin
      failures++;
      $display("FAIL wb_start got req=%b wr=%b addr=%h wdata=%h want req=1 wr=1 addr=00000210 wdata=cafef00d",
               seen, cache_data_wr, cache_data_addr, cache_data_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cache_data_req !== 1'b0) begin
      failures++;
      $display("FAIL wb_abort_req got %b want 0", cache_data_req);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      checks++;
      if (cpu_data_data_ok !== 1'b0) begin
        failures++;
        $display("FAIL wb_abort_data_ok got %b want 0", cpu_data_data_ok);
      end
    end
    rst = 1'b1;
    addr_delay = 0;
    push_mem(1'b0, 2'd2, 32'h0000_0010, 32'd0);
    cpu_op("post_rst_read10", 1'b0, 2'd2, 32'h0000_0010, 32'd0, 32'h1122_AB44, 1'b1, 4, 1);
    push_mem(1'b0, 2'd2, 32'h0000_0210, 32'd0);
    cpu_op("post_rst_read210", 1'b0, 2'd2, 32'h0000_0210, 32'd0, 32'h5566_7788, 1'b1, 4, 1);
  endtask

  task automatic test_delayed_rm();
    addr_delay = 5;
    push_mem(1'b0, 2'd2, 32'h0000_0610, 32'd0);
    cpu_op("delayed_rm", 1'b0, 2'd2, 32'h0000_0610, 32'd0, 32'hDEAD_BEEF, 1'b1, 9, 1);
    addr_delay = 0;
  endtask

  task automatic test_back_to_back();
    combined = 1'b1;
    push_mem(1'b0, 2'd2, 32'h0000_0810, 32'd0);
    cpu_op("combined_miss", 1'b0, 2'd2, 32'h0000_0810, 32'd0, 32'h0BAD_CAFE, 1'b1, 3, 1);
    combined = 1'b0;
    cpu_op("b2b_hit", 1'b0, 2'd2, 32'h0000_0810, 32'd0, 32'h0BAD_CAFE, 1'b1, 1, 0);
    cpu_op("b2b_half", 1'b0, 2'd1, 32'h0000_0812, 32'd0, 32'h0BAD_CAFE, 1'b1, 1, 0);
  endtask

  initial begin
    mem[32'h0000_0010] = 32'h1122_3344;
    mem[32'h0000_0210] = 32'h5566_7788;
    mem[32'h0000_0610] = 32'hDEAD_BEEF;
    mem[32'h0000_0810] = 32'h0BAD_CAFE;
    test_reset();
    test_cold_read();
    test_byte_write();
    test_conflict();
    test_uncached();
    test_reset_wb();
    test_delayed_rm();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_mem_q.size() != 0 || exp_cpu_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got mem=%0d cpu=%0d want 0 0", exp_mem_q.size(), exp_cpu_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
